if_id_queue: RTL

- Buffer between the fetch stage and the decode stage.
- Captures each fetched {pc, pc_next, instruction} when the instruction memory responds, and holds it in a small circular FIFO.
- Presents the oldest entry to decode.
- Absorbs decode stalls so fetch can run up to DEPTH instructions ahead. Gives the PC register a single backpressure signal, and drops wrong-path instructions on a branch flush.

---
 rtl/if_id_queue_pkg.sv | 17 +
 rtl/ifq_fifo_mem.sv | 27 ++
 rtl/if_id_queue.sv | 118 +++++++++++
 3 files changed

// File: rtl/if_id_queue_pkg.sv
// Shared types for the fetch/decode boundary: word type, queue entry payload and the NOP encoding.
package if_id_queue_pkg;

    localparam int unsigned XLEN = 32;

    typedef logic [XLEN-1:0] rv32i_word;

    typedef struct packed {
        rv32i_word pc;
        rv32i_word pc_next;
        rv32i_word instr;
    } if_id_entry_t;

    // addi x0, x0, 0
    localparam rv32i_word NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/ifq_fifo_mem.sv
// DEPTH x if_id_entry_t register array: one synchronous write port, one asynchronous read port.
module ifq_fifo_mem
    import if_id_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               i_we,
    input  logic [PTR_W-1:0]   i_waddr,
    input  if_id_entry_t       i_wdata,
    input  logic [PTR_W-1:0]   i_raddr,
    output if_id_entry_t       o_rdata
);

    if_id_entry_t r_mem [DEPTH];

    // Storage is intentionally not reset; validity is tracked by the owner's count.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/if_id_queue.sv
// Fetch-to-decode circular FIFO with stall absorption, single backpressure signal and branch flush.
// Optional perf counters (stall_cycles, flush_drops) enabled by defining IF_ID_QUEUE_PERF_EN.
module if_id_queue
    import if_id_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       if_pc,
    input  logic [31:0]       if_pc_next,
    input  logic [31:0]       imem_rdata,
    input  logic              imem_resp,
    output logic              if_ready,
    input  logic              flush,
    input  logic              id_stall,
    output logic              id_valid,
    output logic [31:0]       id_pc,
    output logic [31:0]       id_pc_next,
    output logic [31:0]       id_instr,
    output logic [PTR_W:0]    occupancy
`ifdef IF_ID_QUEUE_PERF_EN
    ,
    output logic [31:0]       stall_cycles,
    output logic [31:0]       flush_drops
`endif
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_enq;
    logic             w_deq;
    logic             w_nonempty;
    if_id_entry_t     w_wr_entry;
    if_id_entry_t     w_head;

    // Backpressure depends only on registered count, never on id_stall.
    assign if_ready   = (r_count != FULL_CNT);
    assign w_nonempty = (r_count != '0);
    assign w_enq      = imem_resp & if_ready & ~flush;
    assign w_deq      = w_nonempty & ~id_stall & ~flush;

    assign w_wr_entry = '{pc: if_pc, pc_next: if_pc_next, instr: imem_rdata};

    ifq_fifo_mem #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_enq),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_wr_entry),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_head)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_enq) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_deq) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Head view; an empty queue presents a zeroed NOP so decode sees a harmless bubble.
    assign id_valid   = w_nonempty;
    assign id_pc      = w_nonempty ? w_head.pc      : 32'h0;
    assign id_pc_next = w_nonempty ? w_head.pc_next : 32'h0;
    assign id_instr   = w_nonempty ? w_head.instr   : NOP_INSTR;
    assign occupancy  = r_count;

`ifdef IF_ID_QUEUE_PERF_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_flush_drops;
    logic [32:0] w_drop_sum;

    assign w_drop_sum = {1'b0, r_flush_drops} + 33'(r_count);

    // Saturating event counters.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_stall_cycles <= '0;
            r_flush_drops  <= '0;
        end else begin
            if (imem_resp && !if_ready && (r_stall_cycles != 32'hFFFF_FFFF)) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
            if (flush) begin
                r_flush_drops <= w_drop_sum[32] ? 32'hFFFF_FFFF : w_drop_sum[31:0];
            end
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_drops  = r_flush_drops;
`endif

endmodule
